// File: rtl/axis_s_rx_if.sv
// AXI-Stream beat channel between an upstream master and the axis_s_rx sink.
// The master drives data/valid/last; the slave answers with ready.
interface axis_s_rx_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_s_rx.sv
// AXI-Stream sink: length-checked packet reception into a 4-entry FWFT FIFO,
// with a one-cycle per-packet status strobe (length, short/long errors).
module axis_s_rx #(
    parameter  int WIDTH   = 32,
    parameter  int MAX_LEN = 128,
    localparam int LW      = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    axis_s_rx_if.slave       s_axis,
    input  logic             config_valid,
    input  logic [LW-1:0]    config_len,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             last_out,
    input  logic             ready_in,
    output logic             pkt_done,
    output logic [LW-1:0]    pkt_len,
    output logic             err_short,
    output logic             err_long
);

    localparam logic [LW-1:0] CNT_ONE = {{(LW-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [LW-1:0]    count_r;
    logic [LW-1:0]    len_store_r;
    logic [WIDTH:0]   mem_r [4];
    logic [1:0]       wr_ptr_r;
    logic [1:0]       rd_ptr_r;
    logic [2:0]       fill_r;
    logic             full_s;
    logic             empty_s;
    logic             accept_s;
    logic             end_s;
    logic             pop_s;
    logic [WIDTH:0]   head_s;

    assign full_s   = (fill_r == 3'd4);
    assign empty_s  = (fill_r == 3'd0);
    assign s_axis.tready = (state_r == ST_RUN) && !full_s;
    assign accept_s = s_axis.tvalid & s_axis.tready;
    // count wraps to 0 on the MAX_LEN-th beat, which matches len_store == 0
    assign end_s    = s_axis.tlast | (count_r == len_store_r);
    assign valid_out = !empty_s;
    assign pop_s    = valid_out & ready_in;
    assign head_s   = mem_r[rd_ptr_r];

    // FIFO head presentation, forced to zero when empty
    always_comb begin
        data_out = {WIDTH{1'b0}};
        last_out = 1'b0;
        if (!empty_s) begin
            data_out = head_s[WIDTH-1:0];
            last_out = head_s[WIDTH];
        end else begin
            data_out = {WIDTH{1'b0}};
            last_out = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (config_valid) begin
                    state_nx_s = ST_RUN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (accept_s && end_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Beat counter and latched expected length
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r     <= CNT_ONE;
            len_store_r <= {LW{1'b0}};
        end else begin
            if ((state_r == ST_IDLE) && config_valid) begin
                len_store_r <= config_len;
            end
            if (accept_s) begin
                count_r <= end_s ? CNT_ONE : (count_r + CNT_ONE);
            end
        end
    end

    // FIFO storage; contents are don't-care while their slot is empty
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= {end_s, s_axis.tdata};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            fill_r   <= 3'd0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({accept_s, pop_s})
                2'b10:   fill_r <= fill_r + 3'd1;
                2'b01:   fill_r <= fill_r - 3'd1;
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Per-packet status, registered the cycle after the end beat
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_done  <= 1'b0;
            pkt_len   <= {LW{1'b0}};
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else if (accept_s && end_s) begin
            pkt_done  <= 1'b1;
            pkt_len   <= count_r;
            err_short <= s_axis.tlast & (count_r != len_store_r);
            err_long  <= ~s_axis.tlast & (count_r == len_store_r);
        end else begin
            pkt_done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_s_rx.sv
// Bench for axis_s_rx: directed packets plus a random phase, all checked each
// cycle against a queue-based packet model of the receiver.
module tb_axis_s_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_v;
    logic [6:0]  cfg_len;
    logic        rdy;
    logic        valid_out;
    logic [31:0] data_out;
    logic        last_out;
    logic        pkt_done;
    logic [6:0]  pkt_len;
    logic        err_short;
    logic        err_long;

    axis_s_rx_if #(.WIDTH(32)) s_axis ();

    axis_s_rx #(.WIDTH(32), .MAX_LEN(128)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_axis),
        .config_valid (cfg_v),
        .config_len   (cfg_len),
        .valid_out    (valid_out),
        .data_out     (data_out),
        .last_out     (last_out),
        .ready_in     (rdy),
        .pkt_done     (pkt_done),
        .pkt_len      (pkt_len),
        .err_short    (err_short),
        .err_long     (err_long)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: armed flag, beats so far, expected beats, FIFO queue
    logic [32:0] m_q[$];
    bit          m_armed = 1'b0;
    int          m_cnt   = 0;
    int          m_exp   = 0;
    bit          m_done  = 1'b0;
    int          m_len   = 0;
    bit          m_es    = 1'b0;
    bit          m_el    = 1'b0;
    bit          m_acc   = 1'b0;
    logic [31:0] popped[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic check_outputs();
        logic [32:0] h;
        h = (m_q.size() > 0) ? m_q[0] : 33'd0;
        chk("tready",    32'(s_axis.tready), 32'(m_armed && (m_q.size() < 4)));
        chk("valid_out", 32'(valid_out),     32'(m_q.size() > 0));
        chk("data_out",  data_out,           h[31:0]);
        chk("last_out",  32'(last_out),      32'(h[32]));
        chk("pkt_done",  32'(pkt_done),      32'(m_done));
        if (m_done) begin
            chk("pkt_len",   32'(pkt_len),   32'(m_len));
            chk("err_short", 32'(err_short), 32'(m_es));
            chk("err_long",  32'(err_long),  32'(m_el));
        end
    endtask

    // Advance model and DUT by one clock using the inputs currently applied
    task automatic tick();
        bit ex_rdy, pop, e, done, pre_armed;
        int n;
        e = 1'b0;
        done = 1'b0;
        ex_rdy = m_armed && (m_q.size() < 4);
        m_acc = s_axis.tvalid && ex_rdy && !rst;
        if (valid_out && rdy && !rst) popped.push_back(data_out);
        if (rst) begin
            m_q.delete();
            m_armed = 1'b0; m_cnt = 0; m_len = 0; m_es = 1'b0; m_el = 1'b0;
        end else begin
            pre_armed = m_armed;
            pop = (m_q.size() > 0) && rdy;
            if (m_acc) begin
                n = m_cnt + 1;
                e = s_axis.tlast || (n == m_exp);
                if (e) begin
                    done = 1'b1;
                    m_len = n % 128;
                    m_es = s_axis.tlast && (n < m_exp);
                    m_el = !s_axis.tlast && (n == m_exp);
                    m_armed = 1'b0;
                    m_cnt = 0;
                end else begin
                    m_cnt = n;
                end
            end
            if (pop) void'(m_q.pop_front());
            if (m_acc) m_q.push_back({e, s_axis.tdata});
            if (!pre_armed && cfg_v) begin
                m_armed = 1'b1;
                m_exp = (cfg_len == 7'd0) ? 128 : int'(cfg_len);
                m_cnt = 0;
            end
        end
        m_done = done;
        @(posedge clk);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_config(input logic [6:0] len);
        cfg_v = 1'b1;
        cfg_len = len;
        tick();
        cfg_v = 1'b0;
    endtask

    task automatic beats(input int n, input logic [31:0] base, input int last_idx);
        int b;
        for (int i = 0; i < n; i++) begin
            s_axis.tvalid = 1'b1;
            s_axis.tdata  = base + 32'(i);
            s_axis.tlast  = (i == last_idx);
            b = 0;
            do begin
                tick();
                b++;
            end while (!m_acc && b < 300);
            if (!m_acc) chk("accept_timeout", 32'(m_acc), 32'd1);
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc;
        int b;
        rst = 1'b1; cfg_v = 1'b0; cfg_len = 7'd0; rdy = 1'b1;
        s_axis.tvalid = 1'b0; s_axis.tdata = 32'd0; s_axis.tlast = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Exact-length packet
        popped.delete();
        do_config(7'd4);
        beats(4, 32'hA0, 3);
        repeat (3) tick();
        chk("t1_len", 32'(m_len), 32'd4);
        chk("t1_errs", 32'({m_es, m_el}), 32'd0);
        chk("t1_npop", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("t1_pop", popped[i], 32'hA0 + 32'(i));

        // Short packet
        do_config(7'd5);
        beats(3, 32'h50, 2);
        tick();
        chk("t2_len", 32'(m_len), 32'd3);
        chk("t2_es", 32'(m_es), 32'd1);
        chk("t2_el", 32'(m_el), 32'd0);
        chk("t2_idle", 32'(m_armed), 32'd0);

        // Long packet truncated, remainder received under a new config
        do_config(7'd2);
        beats(2, 32'hC0, -1);
        chk("t3a_len", 32'(m_len), 32'd2);
        chk("t3a_el", 32'(m_el), 32'd1);
        s_axis.tvalid = 1'b1; s_axis.tdata = 32'hC2; s_axis.tlast = 1'b0;
        repeat (3) tick();
        do_config(7'd2);
        beats(2, 32'hC2, 1);
        tick();
        chk("t3b_len", 32'(m_len), 32'd2);
        chk("t3b_errs", 32'({m_es, m_el}), 32'd0);
        repeat (4) tick();

        // Consumer stall fills the FIFO
        rdy = 1'b0;
        do_config(7'd8);
        acc = 0;
        s_axis.tvalid = 1'b1; s_axis.tdata = 32'hB0; s_axis.tlast = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (m_acc) begin acc++; s_axis.tdata = 32'hB0 + 32'(acc); s_axis.tlast = (acc == 7); end
        end
        chk("t4_full_acc", 32'(acc), 32'd4);
        rdy = 1'b1;
        tick();
        if (m_acc) begin acc++; s_axis.tdata = 32'hB0 + 32'(acc); s_axis.tlast = (acc == 7); end
        rdy = 1'b0;
        tick();
        if (m_acc) begin acc++; s_axis.tdata = 32'hB0 + 32'(acc); s_axis.tlast = (acc == 7); end
        chk("t4_one_more", 32'(acc), 32'd5);
        rdy = 1'b1;
        b = 0;
        while (acc < 8 && b < 100) begin
            tick();
            b++;
            if (m_acc) begin acc++; s_axis.tdata = 32'hB0 + 32'(acc); s_axis.tlast = (acc == 7); end
        end
        chk("t4_all_acc", 32'(acc), 32'd8);
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        repeat (6) tick();

        // MAX_LEN packet via len=0
        do_config(7'd0);
        beats(128, 32'h1000, 127);
        tick();
        chk("t5_len", 32'(m_len), 32'd0);
        chk("t5_errs", 32'({m_es, m_el}), 32'd0);
        repeat (3) tick();

        // Reset mid-packet, then a clean packet
        do_config(7'd4);
        beats(2, 32'hE0, -1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_done", 32'(pkt_done), 32'd0);
        chk("t6_valid", 32'(valid_out), 32'd0);
        do_config(7'd4);
        beats(4, 32'hE4, 3);
        tick();
        chk("t6_len", 32'(m_len), 32'd4);
        chk("t6_errs", 32'({m_es, m_el}), 32'd0);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            if (!s_axis.tvalid || m_acc) begin
                s_axis.tvalid = ($urandom % 4) != 0;
                s_axis.tdata  = $urandom;
                s_axis.tlast  = ($urandom % 5) == 0;
            end
            cfg_v   = ($urandom % 6) == 0;
            cfg_len = 7'($urandom % 8);
            rdy     = ($urandom % 4) != 0;
            rst     = ($urandom % 500) == 0;
            tick();
        end
        rst = 1'b0; cfg_v = 1'b0; rdy = 1'b1;
        s_axis.tvalid = 1'b0; s_axis.tlast = 1'b0;
        repeat (8) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_s_rx.md
# axis_s_rx

AXI-Stream slave receive stage that terminates a length-framed stream from an upstream AXI-Stream master. It buffers accepted beats in a 4-entry first-word-fall-through FIFO and presents them to a local consumer on a simple valid/ready port. For each packet it checks the received beat count against a configured expected length, then reports a per-packet status: length, short error, long error. It sits at the sink end of a stream link, mirroring the master-side packetizer.

## Interface
- WIDTH, 32, data width in bits
- MAX_LEN, 128, maximum packet length in beats; LW = $clog2(MAX_LEN)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- s_axis_tdata  input  WIDTH  stream data
- s_axis_tvalid  input  1  stream beat valid
- s_axis_tready  output  1  stream beat accepted when high with tvalid
- s_axis_tlast  input  1  final beat of packet
- config_valid  input  1  arm reception of one packet
- config_len  input  LW  expected beats; 0 encodes MAX_LEN
- valid_out  output  1  FIFO head valid
- data_out  output  WIDTH  FIFO head data
- last_out  output  1  FIFO head is last beat of its packet
- ready_in  input  1  consumer pops head when high with valid_out
- pkt_done  output  1  one-cycle status strobe
- pkt_len  output  LW  beats accepted in finished packet (0 = MAX_LEN)
- err_short  output  1  tlast arrived before expected length (valid with pkt_done)
- err_long  output  1  expected length reached without tlast (valid with pkt_done)

## Operation
- Reset: state IDLE, count=1, len_store=0, FIFO empty. All outputs 0 (s_axis_tready=0, valid_out=0, data_out=0, last_out=0, pkt_done=0, pkt_len=0, errors 0).
- Two states:
  - IDLE: s_axis_tready=0. config_valid=1 latches config_len into len_store and moves to RUN next cycle.
  - RUN: s_axis_tready = ~fifo_full; config_valid is ignored.
- Accept = s_axis_tvalid & s_axis_tready. Each accept pushes {end, tdata} into the FIFO.
  - end = s_axis_tlast | (count == len_store).
- Count rules:
  - count is LW bits, starts at 1 and increments per accept. It wraps naturally, so len_store=0 terminates on the MAX_LEN-th beat.
  - On an accept with end=1: count returns to 1, state goes to IDLE, and status is registered.
- Status, registered the cycle after the end beat:
  - pkt_done=1 for one cycle.
  - pkt_len = count at the end beat.
  - err_short = tlast & (count != len_store).
  - err_long = ~tlast & (count == len_store).
  - Exact match sets both errors to 0.
- Long packets are truncated: last_out is forced on the len-th beat. Beats beyond it stay stalled upstream (tready=0 in IDLE) until the next config, where they are received as a new packet.
- FIFO output:
  - valid_out = ~empty; data_out/last_out show the head combinationally.
  - pop = valid_out & ready_in.
  - data_out/last_out are 0 when empty.
- Buffering: FIFO depth 4, entries WIDTH+1 bits. No write bypass when full; a simultaneous push and pop is allowed only when not full.

## Timing
- s_axis_tready is combinational from registered state and fifo_full; it never depends on s_axis_tvalid.
- Latency: a beat accepted at edge N appears on valid_out/data_out after edge N, i.e. visible in cycle N+1.
- config_valid in IDLE at edge N gives s_axis_tready=1 in cycle N+1 (if not full). The earliest accept is edge N+1.
- Back-to-back packets: the end beat at edge N returns to IDLE in cycle N+1. A config there gives the next accept at edge N+2, for a 1-cycle bubble minimum.
- Full FIFO: with 4 entries held and ready_in=0, tready=0. After a pop at edge N, tready=1 in cycle N+1.
- Reset takes priority mid-packet: the FIFO is flushed, the partial packet is dropped, and no pkt_done is issued.
- Consumer stalls (ready_in=0) never affect status timing. pkt_done follows the upstream end beat, not the pop.

## Test plan
- Config len=4, send 4 beats 0xA0..0xA3 with tlast on the 4th, ready_in=1 → data_out sequence A0..A3 with last_out on A3. pkt_done one cycle after the 4th accept with pkt_len=4, both errors 0.
- Config len=5, send 3 beats with tlast on the 3rd → last_out on beat 3, pkt_len=3, err_short=1, err_long=0, state back to IDLE.
- Config len=2, send 4 beats with tlast on the 4th → last_out forced on beat 2, pkt_len=2, err_long=1. tready stays 0 until a new config; the new config (len=2) receives beats 3–4 with pkt_done, pkt_len=2, both errors 0.
- Config len=8, ready_in=0, tvalid held 1 → exactly 4 accepts, then tready=0. Raising ready_in for one cycle pops 0 and allows one further accept the next cycle; all 8 beats eventually emerge in order.
- Config len=0 (MAX_LEN=128), stream 128 beats with tlast on the last → pkt_len=0 reported, errors 0, no early last_out.
- Assert rst mid-packet after 2 of 4 beats → next cycle all outputs 0, valid_out=0, no pkt_done. A new config and 4-beat packet then complete normally.
